// File: rtl/enoc_route_calc_wh_if.sv
// Flit-side handshake between the input FIFO / switch allocator and the route calculator.
// The slave modport is the route calculator's view; the master modport is the driver's view.
interface enoc_route_calc_wh_if #(
    parameter int unsigned XW = 2,
    parameter int unsigned YW = 2
);
    logic          i_val;
    logic          i_head;
    logic          i_tail;
    logic [XW-1:0] i_x_dest;
    logic [YW-1:0] i_y_dest;
    logic          i_ack;
    logic [0:4]    i_credit_avail;
    logic [0:4]    o_output_req;
    logic          o_busy;
    logic          o_err;

    modport slave (
        input  i_val,
        input  i_head,
        input  i_tail,
        input  i_x_dest,
        input  i_y_dest,
        input  i_ack,
        input  i_credit_avail,
        output o_output_req,
        output o_busy,
        output o_err
    );

    modport master (
        output i_val,
        output i_head,
        output i_tail,
        output i_x_dest,
        output i_y_dest,
        output i_ack,
        output i_credit_avail,
        input  o_output_req,
        input  o_busy,
        input  o_err
    );
endinterface

// File: rtl/enoc_route_calc_wh.sv
// Wormhole route calculator: routes each packet once from its head flit (mesh DOR, torus
// shortest-path DOR, or west-first adaptive) and holds that port until the tail is accepted.
module enoc_route_calc_wh #(
    parameter int unsigned X_NODES  = 4,
    parameter int unsigned Y_NODES  = 4,
    parameter int unsigned X_LOC    = 0,
    parameter int unsigned Y_LOC    = 0,
    parameter int unsigned TORUS    = 0,
    parameter int unsigned ADAPTIVE = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    enoc_route_calc_wh_if.slave  bus
);
    localparam int unsigned XW = (X_NODES > 2) ? $clog2(X_NODES) : 1;
    localparam int unsigned YW = (Y_NODES > 2) ? $clog2(Y_NODES) : 1;

    // One extra bit so node counts and wrap sums are exact.
    localparam logic [XW:0] XN = X_NODES[XW:0];
    localparam logic [YW:0] YN = Y_NODES[YW:0];
    localparam logic [XW:0] XL = X_LOC[XW:0];
    localparam logic [YW:0] YL = Y_LOC[YW:0];

    localparam bit AdaptEn = (ADAPTIVE != 0) && (TORUS == 0);

    localparam logic [0:4] PortC = 5'b10000;
    localparam logic [0:4] PortN = 5'b01000;
    localparam logic [0:4] PortE = 5'b00100;
    localparam logic [0:4] PortS = 5'b00010;
    localparam logic [0:4] PortW = 5'b00001;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e     state_q, state_d;
    logic [0:4] route_q, route_d;
    logic       err_q, err_d;

    logic [XW:0] x_dest, x_dpos;
    logic [YW:0] y_dest, y_dpos;
    logic        x_off, x_pos, y_off, y_pos, dest_oor;
    logic [0:4]  x_port, y_port, route_calc;

    assign x_dest = {1'b0, bus.i_x_dest};
    assign y_dest = {1'b0, bus.i_y_dest};

    always_comb begin
        x_dpos   = '0;
        y_dpos   = '0;
        dest_oor = (x_dest >= XN) || (y_dest >= YN);
        if (TORUS != 0) begin
            // Positive-direction hop count modulo N; ties go positive.
            x_dpos = (x_dest >= XL) ? (x_dest - XL) : (x_dest + XN - XL);
            y_dpos = (y_dest >= YL) ? (y_dest - YL) : (y_dest + YN - YL);
            x_off  = (x_dpos != '0);
            y_off  = (y_dpos != '0);
            x_pos  = (x_dpos <= (XN - x_dpos));
            y_pos  = (y_dpos <= (YN - y_dpos));
        end else begin
            x_off = (x_dest != XL);
            y_off = (y_dest != YL);
            x_pos = (x_dest > XL);
            y_pos = (y_dest > YL);
        end
        x_port = x_pos ? PortE : PortW;
        y_port = y_pos ? PortN : PortS;

        route_calc = PortC;
        if (dest_oor) begin
            route_calc = PortC;
        end else if (AdaptEn && x_off && x_pos && y_off) begin
            // Take the y hop only when it alone has credit; otherwise prefer east.
            route_calc = ((|(y_port & bus.i_credit_avail)) && !bus.i_credit_avail[2]) ?
                         y_port : PortE;
        end else if (x_off) begin
            route_calc = x_port;
        end else if (y_off) begin
            route_calc = y_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            route_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_val && bus.i_head) begin
                    route_d = route_calc;
                    state_d = StLocked;
                    if (dest_oor) begin
                        err_d = 1'b1;
                    end
                end else if (bus.i_val) begin
                    err_d = 1'b1;
                end
            end
            StLocked: begin
                if (bus.i_val && bus.i_head) begin
                    err_d = 1'b1;
                end
                if (bus.i_val && bus.i_ack && bus.i_tail) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_busy       = (state_q == StLocked);
        bus.o_output_req = ((state_q == StLocked) && bus.i_val) ? route_q : 5'b00000;
        bus.o_err        = err_q;
    end
endmodule

// File: tb/tb_enoc_route_calc_wh.sv
// Bench for enoc_route_calc_wh: four configurations share one stimulus stream and are checked
// against a packet-level reference model plus directed expectations.
module tb_enoc_route_calc_wh;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       val = 1'b0, head = 1'b0, tail = 1'b0, ack = 1'b0;
    logic [1:0] xd = '0, yd = '0;
    logic [0:4] cr = '0;

    logic [0:4] req_a  [4];
    logic       busy_a [4];
    logic       err_a  [4];

    int checks = 0;
    int errors = 0;

    // 0: mesh 4x4 @(1,1)  1: torus 4x4 @(0,0)  2: adaptive mesh 4x4 @(1,1)  3: mesh 3x3 @(1,1)
    for (genvar g = 0; g < 4; g++) begin : g_dut
        enoc_route_calc_wh_if #(.XW(2), .YW(2)) bus ();
        assign bus.i_val          = val;
        assign bus.i_head         = head;
        assign bus.i_tail         = tail;
        assign bus.i_x_dest       = xd;
        assign bus.i_y_dest       = yd;
        assign bus.i_ack          = ack;
        assign bus.i_credit_avail = cr;
        assign req_a[g]  = bus.o_output_req;
        assign busy_a[g] = bus.o_busy;
        assign err_a[g]  = bus.o_err;
        enoc_route_calc_wh #(
            .X_NODES  (g == 3 ? 3 : 4),
            .Y_NODES  (g == 3 ? 3 : 4),
            .X_LOC    (g == 1 ? 0 : 1),
            .Y_LOC    (g == 1 ? 0 : 1),
            .TORUS    (g == 1 ? 1 : 0),
            .ADAPTIVE (g == 2 ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .reset_n (rst_n),
            .bus     (bus)
        );
    end

    function automatic int nodes(input int k);
        return (k == 3) ? 3 : 4;
    endfunction

    function automatic int loc(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    // Reference routing decision from the routing rules, in plain integer arithmetic.
    function automatic logic [0:4] ref_route(input int k, input int x, input int y,
                                             input logic [0:4] c);
        int n, l, dx, dy;
        bit xo, yo, xp, yp;
        logic [0:4] xport, yport;
        n = nodes(k);
        l = loc(k);
        if (x >= n || y >= n) return 5'b10000;
        if (k == 1) begin
            dx = (x - l + n) % n;
            dy = (y - l + n) % n;
            xo = (dx != 0);
            yo = (dy != 0);
            xp = (dx <= n - dx);
            yp = (dy <= n - dy);
        end else begin
            xo = (x != l);
            yo = (y != l);
            xp = (x > l);
            yp = (y > l);
        end
        xport = xp ? 5'b00100 : 5'b00001;
        yport = yp ? 5'b01000 : 5'b00010;
        if (k == 2 && xo && xp && yo) begin
            if (((c & yport) != 5'b00000) && (c[2] == 1'b0)) return yport;
            return 5'b00100;
        end
        if (xo) return xport;
        if (yo) return yport;
        return 5'b10000;
    endfunction

    logic       m_lock  [4];
    logic [0:4] m_route [4];
    logic       m_err   [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_lock[k]  <= 1'b0;
                m_route[k] <= 5'b00000;
                m_err[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!m_lock[k]) begin
                    if (val && head) begin
                        m_lock[k]  <= 1'b1;
                        m_route[k] <= ref_route(k, int'(xd), int'(yd), cr);
                        if (int'(xd) >= nodes(k) || int'(yd) >= nodes(k)) m_err[k] <= 1'b1;
                    end else if (val) begin
                        m_err[k] <= 1'b1;
                    end
                end else begin
                    if (val && head) m_err[k] <= 1'b1;
                    if (val && ack && tail) m_lock[k] <= 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic h, input logic t, input logic a,
                         input int x, input int y, input logic [0:4] c);
        @(posedge clk);
        #1;
        val  = v;
        head = h;
        tail = t;
        ack  = a;
        xd   = x[1:0];
        yd   = y[1:0];
        cr   = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_a[k] !== 5'b00000 || busy_a[k] !== 1'b0 || err_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d req=%b busy=%b err=%b want 00000/0/0",
                         k, req_a[k], busy_a[k], err_a[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mesh_dor();
        logic [0:4] exp_r [5] = '{5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
        logic       exp_b [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int s = 0; s < 5; s++) begin
            case (s)
                0:       drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 0, 5'b00000);
                1:       drive(1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 5'b00000);
                2:       drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 0, 5'b00000);
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
            endcase
            checks++;
            if (req_a[0] !== exp_r[s] || busy_a[0] !== exp_b[s]) begin
                errors++;
                $display("FAIL mesh_east step%0d req=%b busy=%b want %b/%b",
                         s, req_a[0], busy_a[0], exp_r[s], exp_b[s]);
            end
            for (int k = 0; k < 4; k++) begin
                logic [0:4] er;
                er = (m_lock[k] && val) ? m_route[k] : 5'b00000;
                checks++;
                if (req_a[k] !== er || busy_a[k] !== m_lock[k] || err_a[k] !== m_err[k]) begin
                    errors++;
                    $display("FAIL mesh_model dut%0d req=%b/%b busy=%b/%b err=%b/%b", k,
                             req_a[k], er, busy_a[k], m_lock[k], err_a[k], m_err[k]);
                end
            end
        end
    endtask

    task automatic test_torus();
        int         dx   [3] = '{3, 2, 0};
        int         dy   [3] = '{0, 0, 3};
        logic [0:4] want [3] = '{5'b00001, 5'b00100, 5'b00010};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, dx[i], dy[i], 5'b00000);
            drive(1'b1, 1'b0, 1'b1, 1'b1, dx[i], dy[i], 5'b00000);
            checks++;
            if (req_a[1] !== want[i] || busy_a[1] !== 1'b1) begin
                errors++;
                $display("FAIL torus dest(%0d,%0d) req=%b busy=%b want %b/1",
                         dx[i], dy[i], req_a[1], busy_a[1], want[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        checks++;
        if (busy_a[1] !== 1'b0 || err_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL torus_idle busy=%b err=%b want 0/0", busy_a[1], err_a[1]);
        end
    endtask

    task automatic test_adaptive();
        // Credit only on north: north; credit then moves to east mid-packet, route holds.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 3, 5'b01000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 5'b00100);
        checks++;
        if (req_a[2] !== 5'b01000) begin
            errors++;
            $display("FAIL adapt_north req=%b want 01000", req_a[2]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 3, 5'b00101);
        checks++;
        if (req_a[2] !== 5'b01000) begin
            errors++;
            $display("FAIL adapt_hold req=%b want 01000", req_a[2]);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 3, 5'b01100);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 3, 5'b00000);
        checks++;
        if (req_a[2] !== 5'b00100) begin
            errors++;
            $display("FAIL adapt_both_east req=%b want 00100", req_a[2]);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 3, 5'b01000);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 5'b01000);
        checks++;
        if (req_a[2] !== 5'b00001) begin
            errors++;
            $display("FAIL adapt_west_first req=%b want 00001", req_a[2]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
    endtask

    task automatic test_single_and_abort();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 5'b00000);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 5'b00000);
        checks++;
        if (req_a[0] !== 5'b10000 || busy_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_local req=%b busy=%b want 10000/1", req_a[0], busy_a[0]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        checks++;
        if (busy_a[0] !== 1'b0 || req_a[0] !== 5'b00000) begin
            errors++;
            $display("FAIL single_idle req=%b busy=%b want 00000/0", req_a[0], busy_a[0]);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 5'b00000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 5'b00000);
        checks++;
        if (busy_a[0] !== 1'b1 || req_a[0] !== 5'b00100) begin
            errors++;
            $display("FAIL abort_pre req=%b busy=%b want 00100/1", req_a[0], busy_a[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy_a[k] !== 1'b0 || req_a[k] !== 5'b00000) begin
                errors++;
                $display("FAIL abort_reset dut%0d req=%b busy=%b want 00000/0",
                         k, req_a[k], busy_a[k]);
            end
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
    endtask

    task automatic test_errors();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 5'b00000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (err_a[k] !== 1'b1 || busy_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL body_in_idle dut%0d err=%b busy=%b want 1/0",
                         k, err_a[k], busy_a[k]);
            end
        end
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 0, 5'b00000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 5'b00000);
        checks++;
        if (req_a[3] !== 5'b10000 || err_a[3] !== 1'b1 || err_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_route req=%b err3=%b err0=%b want 10000/1/0",
                     req_a[3], err_a[3], err_a[0]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 0, 5'b00000);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        checks++;
        if (err_a[3] !== 1'b1 || busy_a[3] !== 1'b0) begin
            errors++;
            $display("FAIL oor_sticky err=%b busy=%b want 1/0", err_a[3], busy_a[3]);
        end
        // A second head inside a packet flags an error but the held route stays.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2, 2, 5'b00000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 5'b00000);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 5'b00000);
        checks++;
        if (req_a[0] !== 5'b00100 || err_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL head_in_locked req=%b err=%b want 00100/1", req_a[0], err_a[0]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5'b00000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (err_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL err_cleared dut%0d err=%b want 0", k, err_a[k]);
            end
        end
    endtask

    task automatic test_random();
        int rem = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic v, h, t, a;
            int x, y;
            x = $urandom_range(0, 3);
            y = $urandom_range(0, 3);
            h = 1'b0;
            t = 1'b0;
            a = ($urandom_range(0, 1) == 1);
            if (!m_lock[0]) begin
                v = ($urandom_range(0, 3) != 0);
                h = v;
                rem = $urandom_range(1, 3);
            end else begin
                v = ($urandom_range(0, 3) != 0);
                t = (rem == 1);
            end
            drive(v, h, t, a, x, y, 5'($urandom_range(0, 31)));
            for (int k = 0; k < 4; k++) begin
                logic [0:4] er;
                er = (m_lock[k] && val) ? m_route[k] : 5'b00000;
                checks++;
                if (req_a[k] !== er || busy_a[k] !== m_lock[k] || err_a[k] !== m_err[k]) begin
                    errors++;
                    $display("FAIL random c%0d dut%0d req=%b/%b busy=%b/%b err=%b/%b", c, k,
                             req_a[k], er, busy_a[k], m_lock[k], err_a[k], m_err[k]);
                end
            end
            if (m_lock[0] && v && a && !h && rem > 0) rem--;
        end
    endtask

    initial begin
        test_reset();
        test_mesh_dor();
        test_torus();
        test_adaptive();
        test_single_and_abort();
        test_errors();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enoc_route_calc_wh.md
Name: enoc_route_calc_wh

Overview:
Registered, packet-aware route calculator for one ENoC router input port.
- Computes the output port once per packet from the head flit, using dimension-ordered routing (DOR) in mesh or shortest-path DOR in torus. Optionally uses west-first minimal-adaptive routing in mesh.
- Holds the route for every flit of the wormhole packet until the tail flit is accepted.
- Sits between the input FIFO and the switch allocator.

Parameters:
- X_NODES, 4, number of node columns (>=2)
- Y_NODES, 4, number of node rows (>=2)
- X_LOC, 0, this router's column
- Y_LOC, 0, this router's row
- TORUS, 0, 0 = mesh, 1 = torus (wrap links)
- ADAPTIVE, 0, 1 = west-first minimal adaptive (mesh only; forced to 0 when TORUS=1)

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_val  input  1  flit valid at head of input FIFO
- i_head  input  1  flit is a head flit
- i_tail  input  1  flit is a tail flit (head and tail both set = single-flit packet)
- i_x_dest  input  XW  destination column, XW = max(1, clog2(X_NODES))
- i_y_dest  input  YW  destination row, YW = max(1, clog2(Y_NODES))
- i_ack  input  1  switch allocator accepted the current flit
- i_credit_avail  input  [0:4]  downstream credit available per port [c,n,e,s,w]
- o_output_req  output  [0:4]  one-hot request [c,n,e,s,w]
- o_busy  output  1  route locked (packet in flight)
- o_err  output  1  sticky error flag

Behaviour:
- Port index mapping: c=0, n=1 (+y), e=2 (+x), s=3 (-y), w=4 (-x).
- Reset (asynchronous, reset_n=0):
  - state=IDLE, route register=0, o_output_req=0, o_busy=0, o_err=0.
  - Reset asserted mid-packet abandons the lock immediately.
- FSM states: IDLE and LOCKED.
- IDLE:
  - o_output_req=0 and o_busy=0.
  - When i_val && i_head: the route is computed combinationally and registered at the next clk edge, and state goes to LOCKED.
  - Route latency: 1 cycle from head presentation to request.
  - i_ack in IDLE is ignored.
  - i_val with i_head=0: stay IDLE and set o_err.
- LOCKED:
  - o_busy=1.
  - o_output_req = route register when i_val=1, else 0.
  - On i_val && i_ack && i_tail: go to IDLE next cycle.
  - A single-flit packet also goes LOCKED, then returns to IDLE on its ack.
  - A back-to-back head after a tail is routed in the following IDLE cycle, so there is one bubble cycle per packet.
  - i_val && i_head with no preceding tail: set o_err, keep the current route.
- Mesh DOR, deterministic:
  - If x_dest != X_LOC: east if greater, west if less.
  - Else if y_dest != Y_LOC: north if greater, south if less.
  - Else: local.
- Torus DOR:
  - Positive distance d+ = (dest - loc) mod N; go positive if d+ <= N - d+, else negative.
  - Tie (d+ == N/2) goes positive (east/north).
  - Arithmetic is done in XW+1 / YW+1 bits; no reliance on truncation.
- Adaptive (mesh, ADAPTIVE=1):
  - If x_dest < X_LOC: go west, deterministic (west-first).
  - If x offset > 0 and y offset != 0: choose east or the productive y port.
    - If i_credit_avail differs between the two, pick the one with credit.
    - If both or neither have credit, pick east.
  - Single-dimension offsets and local are as DOR.
  - Credit is sampled only on the head-decision cycle; the route never changes mid-packet.
- Out-of-range destination (x_dest >= X_NODES or y_dest >= Y_NODES):
  - Route to local (c) so the packet drains.
  - Set o_err.
- o_err is sticky until reset.
- o_output_req is always one-hot or zero; it is never multi-hot.

Test Plan:
- Mesh 4x4 at (1,1), head to (3,0), tail two flits later, ack every cycle:
  - Cycle after head: o_output_req=00100 (east), o_busy=1.
  - Held through the tail; IDLE one cycle after the tail ack.
- Torus 4x4 at (0,0), head to (3,0): west 00001. Head to (2,0), tie: east 00100. Head to (0,3): south 00010.
- Adaptive mesh at (1,1), dest (3,3):
  - i_credit_avail=01000: north 01000.
  - i_credit_avail=01100: east.
  - Credit changes mid-packet: request unchanged.
- Adaptive mesh, dest (0,3) with credit only on north: west 00001 (west-first).
- Single-flit packet (head+tail) to (1,1) at (1,1): c=10000 for one cycle after ack, then IDLE. reset_n pulsed low while LOCKED: o_busy=0 and o_output_req=0 immediately.
- Protocol errors: body flit in IDLE sets o_err=1. On a 3x3 mesh, dest x=3 routes to c and o_err stays 1 until reset.
